// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a 2-entry prefetch buffer.
// Memory reads have a fixed 1-cycle latency. A redirect flushes the buffer and
// drops any response still in flight. Requests are throttled so that the
// buffered words plus the in-flight word never exceed 2.
// Optional build macro IFETCH_PERF_EN adds the stall_cnt performance counter.
//
// state | meaning
// IDLE  | no new requests issued; in-flight responses are still captured
// RUN   | requests issued whenever the buffer has room
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        fetch_en,
    output logic        MemRead,
    output logic [15:0] ADDR,
    input  logic [15:0] Mem_Data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr,
    output logic [15:0] instr_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  occ_q, occ_d;
    logic        inflight_q;
    logic [15:0] req_pc_q;
    logic        rd_ptr_q, wr_ptr_q;
    logic [15:0] buf_instr_q [2];
    logic [15:0] buf_pc_q    [2];

    logic        push, pop;
    logic [1:0]  level;

    assign instr_valid = (occ_q != 2'd0);
    assign instr       = buf_instr_q[rd_ptr_q];
    assign instr_pc    = buf_pc_q[rd_ptr_q];
    assign ADDR        = pc_q;

    // Next-state, issue and buffer-control decisions; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        occ_d   = occ_q;
        MemRead = 1'b0;
        pop     = 1'b0;
        push    = 1'b0;
        level   = 2'd0;
        if (redirect) begin
            pc_d  = redirect_pc;
            occ_d = 2'd0;
        end else begin
            pop   = instr_valid && instr_ready;
            push  = inflight_q;
            // A word leaving this cycle frees its slot, which keeps streaming gap-free.
            level = occ_q + 2'(inflight_q) - 2'(pop);
            case (state_q)
                IDLE: if (fetch_en) state_d = RUN;
                RUN: begin
                    MemRead = (level < 2'd2);
                    if (!fetch_en) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (MemRead) pc_d = pc_q + 16'd1;
            occ_d = occ_q + 2'(push) - 2'(pop);
        end
    end

    // Control state: FSM, pc, occupancy and in-flight tracking.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            req_pc_q   <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            occ_q      <= occ_d;
            inflight_q <= MemRead;
            if (MemRead) req_pc_q <= pc_q;
        end
    end

    // Prefetch buffer storage and pointers; a flush rewinds both pointers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_instr_q[i] <= 16'h0000;
                buf_pc_q[i]    <= 16'h0000;
            end
        end else if (redirect) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            if (push) begin
                buf_instr_q[wr_ptr_q] <= Mem_Data;
                buf_pc_q[wr_ptr_q]    <= req_pc_q;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [15:0] stall_q;

    // Count RUN cycles with nothing to deliver, saturating at all-ones.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            stall_q <= 16'h0000;
        end else if (state_q == RUN && !instr_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: behavioural 1-cycle memory, scoreboard of expected
// {instr, pc} pushed on each request and popped on each delivered word, plus
// directed timing checks for start-up, back-pressure, redirect and reset.
module tb_instr_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        CLK;
    logic        reset;
    logic        fetch_en;
    logic        MemRead;
    logic [15:0] ADDR;
    logic [15:0] Mem_Data;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
`ifdef IFETCH_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q [$];
    logic [31:0] sb_e;
    logic [15:0] exp_pc;
    logic [15:0] rd_addr_q;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .MemRead     (MemRead),
        .ADDR        (ADDR),
        .Mem_Data    (Mem_Data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
`ifdef IFETCH_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a < 16'd2) ? 16'h27E7 : (a ^ 16'h5A3C);
    endfunction

    // Memory: returns the word for the address presented in the previous cycle.
    always @(posedge CLK) rd_addr_q <= ADDR;
    assign Mem_Data = mem_word(rd_addr_q);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge CLK) begin
        if (!reset) begin
            sb_q.delete();
            exp_pc = RESET_PC;
        end else if (redirect) begin
            check("redir_memread", 32'(MemRead), 32'd0);
            sb_q.delete();
            exp_pc = redirect_pc;
        end else begin
            if (MemRead) begin
                check("req_addr", 32'(ADDR), 32'(exp_pc));
                sb_q.push_back({mem_word(exp_pc), exp_pc});
                exp_pc = exp_pc + 16'd1;
            end
            if (instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", 32'(sb_q.size()), 32'd1);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_instr", 32'(instr), 32'(sb_e[31:16]));
                    check("sb_pc", 32'(instr_pc), 32'(sb_e[15:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failed %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int          nreq;
        int          k;
        logic [15:0] exp_addr [3];

        reset       = 1'b0;
        fetch_en    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;

        // Reset state
        repeat (2) tick();
        @(negedge CLK);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_addr", 32'(ADDR), 32'(RESET_PC));
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);

        // Start-up and streaming timing
        tick();
        reset = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        @(negedge CLK);
        check("c0_memread", 32'(MemRead), 32'd0);
        check("c0_valid", 32'(instr_valid), 32'd0);
        @(negedge CLK);
        check("c1_memread", 32'(MemRead), 32'd1);
        check("c1_addr", 32'(ADDR), 32'h0000);
        @(negedge CLK);
        check("c2_memread", 32'(MemRead), 32'd1);
        check("c2_addr", 32'(ADDR), 32'h0001);
        check("c2_valid", 32'(instr_valid), 32'd0);
        @(negedge CLK);
        check("c3_valid", 32'(instr_valid), 32'd1);
        check("c3_instr", 32'(instr), 32'h27E7);
        check("c3_pc", 32'(instr_pc), 32'h0000);
        check("c3_memread", 32'(MemRead), 32'd1);
`ifdef IFETCH_PERF_EN
        check("c3_stall", 32'(stall_cnt), 32'd2);
`endif
        @(negedge CLK);
        check("c4_instr", 32'(instr), 32'h27E7);
        check("c4_pc", 32'(instr_pc), 32'h0001);
        @(negedge CLK);
        check("c5_pc", 32'(instr_pc), 32'h0002);
        check("c5_instr", 32'(instr), 32'(mem_word(16'h0002)));
        @(negedge CLK);
        check("c6_pc", 32'(instr_pc), 32'h0003);
        check("c6_valid", 32'(instr_valid), 32'd1);
        repeat (4) @(negedge CLK);
`ifdef IFETCH_PERF_EN
        check("stream_stall", 32'(stall_cnt), 32'd2);
`endif

        // Reset mid-stream clears outputs immediately
        tick();
        reset = 1'b0;
        #1;
        check("mrst_valid", 32'(instr_valid), 32'd0);
        check("mrst_memread", 32'(MemRead), 32'd0);
        check("mrst_addr", 32'(ADDR), 32'(RESET_PC));
        check("mrst_instr_pc", 32'(instr_pc), 32'd0);
`ifdef IFETCH_PERF_EN
        check("mrst_stall", 32'(stall_cnt), 32'd0);
`endif
        repeat (2) tick();

        // Back-pressure: buffer fills with exactly two words
        reset = 1'b1; instr_ready = 1'b0;
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (MemRead) nreq++;
        end
        check("bp_nreq", 32'(nreq), 32'd2);
        check("bp_memread", 32'(MemRead), 32'd0);
        check("bp_valid", 32'(instr_valid), 32'd1);
        check("bp_head_pc", 32'(instr_pc), 32'(RESET_PC));
        tick();
        instr_ready = 1'b1;
        @(negedge CLK);
        check("bp_out0_pc", 32'(instr_pc), 32'h0000);
        @(negedge CLK);
        check("bp_out1_pc", 32'(instr_pc), 32'h0001);
        @(negedge CLK);
        check("bp_out2_pc", 32'(instr_pc), 32'h0002);
        repeat (3) tick();

        // Redirect with one word buffered and one in flight
        redirect = 1'b1; redirect_pc = 16'h0100;
        @(negedge CLK);
        check("rd_occupied", 32'(instr_valid), 32'd1);
        tick();
        redirect = 1'b0;
        @(negedge CLK);
        check("rd1_valid", 32'(instr_valid), 32'd0);
        check("rd1_memread", 32'(MemRead), 32'd1);
        check("rd1_addr", 32'(ADDR), 32'h0100);
        @(negedge CLK);
        check("rd2_valid", 32'(instr_valid), 32'd0);
        @(negedge CLK);
        check("rd3_valid", 32'(instr_valid), 32'd1);
        check("rd3_pc", 32'(instr_pc), 32'h0100);
        repeat (2) tick();

        // Redirect to the top of the address space: pc wraps
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        exp_addr[0] = 16'hFFFF; exp_addr[1] = 16'h0000; exp_addr[2] = 16'h0001;
        k = 0;
        for (int i = 0; i < 10 && k < 3; i++) begin
            @(negedge CLK);
            if (MemRead) begin
                check("wrap_addr", 32'(ADDR), 32'(exp_addr[k]));
                k++;
            end
        end
        check("wrap_count", 32'(k), 32'd3);
        repeat (3) tick();

        // Leaving RUN keeps the in-flight response; everything drains
        fetch_en = 1'b0;
        repeat (6) tick();
        @(negedge CLK);
        check("drain_valid", 32'(instr_valid), 32'd0);
        check("drain_memread", 32'(MemRead), 32'd0);
        check("drain_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
